// File: rtl/lcd_bus_scheduler_if.sv
// Client handshake and LCD pin bundle for lcd_bus_scheduler.
// The scheduler takes the slave side; the clients and the LCD pins sit on the master side.
interface lcd_bus_scheduler_if;
  logic       req0_valid;
  logic       req0_rs;
  logic       req0_single;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic       req1_single;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       busy;
  logic       grant;
  logic       en;
  logic       rs;
  logic [3:0] data;

  modport master (
    output req0_valid, req0_rs, req0_single, req0_data,
    output req1_valid, req1_rs, req1_single, req1_data,
    input  req0_ready, req1_ready, busy, grant, en, rs, data
  );

  modport slave (
    input  req0_valid, req0_rs, req0_single, req0_data,
    input  req1_valid, req1_rs, req1_single, req1_data,
    output req0_ready, req1_ready, busy, grant, en, rs, data
  );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// Round-robin owner of the HD44780 4-bit bus: splits bytes into nibble strobes
// and inserts the settling gap after each write.
module lcd_bus_scheduler #(
  parameter int unsigned SHORT_GAP = 1,
  parameter int unsigned LONG_GAP  = 5
) (
  input  logic                clk,
  input  logic                reset,
  lcd_bus_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI_EN = 3'd1,
    HI_LO = 3'd2,
    LO_EN = 3'd3,
    LO_LO = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] SHORT_GAP_W = 8'(SHORT_GAP);
  localparam logic [7:0] LONG_GAP_W  = 8'(LONG_GAP);

  state_t     state_r;
  logic [7:0] gap_cnt_r;
  logic       rs_l_r;
  logic       single_l_r;
  logic [7:0] data_l_r;
  logic       grant_r;
  logic       busy_r;
  logic       en_r;
  logic       rs_pin_r;
  logic [3:0] data_pin_r;

  logic       win0_s;
  logic       win1_s;
  logic       ready0_s;
  logic       ready1_s;
  logic       sel_rs_s;
  logic       sel_single_s;
  logic [7:0] sel_data_s;
  logic [7:0] gap_len_s;

  // Clear/home and the power-on nibbles need the long settling time.
  function automatic logic is_long(input logic single, input logic rs, input logic [7:0] d);
    return single || (!rs && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03)));
  endfunction

  // Arbitration, handshake and selection of the winning client's fields.
  always_comb begin
    win0_s       = 1'b0;
    win1_s       = 1'b0;
    sel_rs_s     = 1'b0;
    sel_single_s = 1'b0;
    sel_data_s   = 8'h00;
    if (bus.req0_valid && (!bus.req1_valid || grant_r)) begin
      win0_s = 1'b1;
    end else begin
      win0_s = 1'b0;
    end
    if (bus.req1_valid && (!bus.req0_valid || !grant_r)) begin
      win1_s = 1'b1;
    end else begin
      win1_s = 1'b0;
    end
    ready0_s = win0_s && (state_r == IDLE) && !reset;
    ready1_s = win1_s && (state_r == IDLE) && !reset;
    if (ready1_s) begin
      sel_rs_s     = bus.req1_rs;
      sel_single_s = bus.req1_single;
      sel_data_s   = bus.req1_data;
    end else begin
      sel_rs_s     = bus.req0_rs;
      sel_single_s = bus.req0_single;
      sel_data_s   = bus.req0_data;
    end
    gap_len_s = is_long(single_l_r, rs_l_r, data_l_r) ? LONG_GAP_W : SHORT_GAP_W;
  end

  // Transfer sequencer; pins are set on the edge that enters each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      gap_cnt_r  <= 8'd0;
      rs_l_r     <= 1'b0;
      single_l_r <= 1'b0;
      data_l_r   <= 8'h00;
      grant_r    <= 1'b1;
      busy_r     <= 1'b0;
      en_r       <= 1'b0;
      rs_pin_r   <= 1'b0;
      data_pin_r <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ready0_s || ready1_s) begin
            grant_r    <= ready1_s;
            rs_l_r     <= sel_rs_s;
            single_l_r <= sel_single_s;
            data_l_r   <= sel_data_s;
            en_r       <= 1'b1;
            rs_pin_r   <= sel_rs_s;
            data_pin_r <= sel_data_s[7:4];
            busy_r     <= 1'b1;
            state_r    <= HI_EN;
          end else begin
            state_r    <= IDLE;
          end
        end
        HI_EN: begin
          en_r    <= 1'b0;
          state_r <= HI_LO;
        end
        HI_LO, LO_LO: begin
          if ((state_r == HI_LO) && !single_l_r) begin
            en_r       <= 1'b1;
            data_pin_r <= data_l_r[3:0];
            state_r    <= LO_EN;
          end else if (gap_len_s == 8'd0) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_len_s;
            state_r   <= GAP;
          end
        end
        LO_EN: begin
          en_r    <= 1'b0;
          state_r <= LO_LO;
        end
        GAP: begin
          if (gap_cnt_r <= 8'd1) begin
            gap_cnt_r <= 8'd0;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
        default: begin
          en_r      <= 1'b0;
          busy_r    <= 1'b0;
          gap_cnt_r <= 8'd0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.busy       = busy_r;
  assign bus.grant      = grant_r;
  assign bus.en         = en_r;
  assign bus.rs         = rs_pin_r;
  assign bus.data       = data_pin_r;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: per-cycle timing-rule model,
// directed vector table, multi-cycle corner sequences and random traffic.
module tb_lcd_bus_scheduler;
  localparam int SHORT_GAP = 1;
  localparam int LONG_GAP  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_bus_scheduler_if bus();

  lcd_bus_scheduler #(.SHORT_GAP(SHORT_GAP), .LONG_GAP(LONG_GAP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit       client;
    bit       rs;
    bit       single;
    bit [7:0] data;
    int       exp_pulses;
    bit [4:0] exp_p1;   // {rs, nibble} on the first en pulse
    bit [4:0] exp_p2;   // {rs, nibble} on the second en pulse
    int       exp_next; // cycles from acceptance until the bus is free again
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: transfer timing expressed relative to the acceptance cycle
  bit       m_grant = 1'b1;
  bit       m_has = 1'b0;
  int       m_free = 0;
  int       m_t = 0;
  bit       m_rs, m_single;
  bit [7:0] m_data;
  bit       acc0, acc1;

  logic       obs_en, obs_rs, obs_busy, obs_grant, obs_r0, obs_r1;
  logic [3:0] obs_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model, then advance the model.
  task automatic cycle();
    bit v0, v1, idle, w0, w1, er0, er1, een, ers, lng, idx;
    bit [3:0] edata;
    int rel;
    @(negedge clk);
    obs_en = bus.en; obs_rs = bus.rs; obs_data = bus.data; obs_busy = bus.busy;
    obs_grant = bus.grant; obs_r0 = bus.req0_ready; obs_r1 = bus.req1_ready;
    v0 = bus.req0_valid; v1 = bus.req1_valid;
    idle = (cyc >= m_free);
    w0 = v0 && (!v1 || m_grant);
    w1 = v1 && (!v0 || !m_grant);
    er0 = !reset && idle && w0;
    er1 = !reset && idle && w1;
    een = 1'b0; ers = 1'b0; edata = 4'h0;
    if (m_has) begin
      rel = cyc - m_t;
      een = (rel == 1) || (rel == 3 && !m_single);
      ers = m_rs;
      edata = (rel <= 2 || m_single) ? m_data[7:4] : m_data[3:0];
    end
    check("cycle", {22'd0, obs_r0, obs_r1, obs_busy, obs_grant, obs_en, obs_rs, obs_data},
          {22'd0, er0, er1, !idle, m_grant, een, ers, edata});
    acc0 = er0; acc1 = er1;
    if (reset) begin
      m_grant = 1'b1; m_has = 1'b0; m_free = cyc + 1;
    end else if (er0 || er1) begin
      idx = er1;
      m_grant = idx; m_t = cyc; m_has = 1'b1;
      m_rs = idx ? bus.req1_rs : bus.req0_rs;
      m_single = idx ? bus.req1_single : bus.req0_single;
      m_data = idx ? bus.req1_data : bus.req0_data;
      lng = m_single || (!m_rs && m_data >= 8'h01 && m_data <= 8'h03);
      m_free = cyc + (m_single ? 3 : 5) + (lng ? LONG_GAP : SHORT_GAP);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit n, input bit v, input bit rs, input bit s, input bit [7:0] d);
    if (n) begin
      bus.req1_valid = v; bus.req1_rs = rs; bus.req1_single = s; bus.req1_data = d;
    end else begin
      bus.req0_valid = v; bus.req0_rs = rs; bus.req0_single = s; bus.req0_data = d;
    end
  endtask

  initial begin
    vec_t     tbl[8];
    int       waitc, pulses, first_free, npulse, nacc, pend_grant;
    bit [4:0] p[3];
    bit [7:0] byte_asm;
    bit       p_valid[2], p_rs[2], p_single[2];
    bit [7:0] p_data[2];

    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h28, 2, 5'h02, 5'h08, 6};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h01, 2, 5'h00, 5'h01, 10};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h01, 2, 5'h10, 5'h11, 6};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h30, 1, 5'h03, 5'h00, 8};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h02, 2, 5'h00, 5'h02, 10};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h04, 2, 5'h00, 5'h04, 6};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h2F, 1, 5'h12, 5'h00, 8};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'hA5, 2, 5'h1A, 5'h15, 6};

    // reset with both clients requesting
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h28);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    @(posedge clk);
    #1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("ready0_after_reset", {31'd0, obs_r0}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (12) cycle();

    // directed table
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].client, 1'b1, tbl[i].rs, tbl[i].single, tbl[i].data);
      waitc = 0;
      acc0 = 1'b0; acc1 = 1'b0;
      while (!(acc0 || acc1) && waitc < 40) begin
        cycle();
        waitc++;
      end
      check("accept_timeout", {31'd0, (acc0 || acc1)}, 32'd1);
      // garbage after acceptance must not disturb the transfer in flight
      drive(tbl[i].client, 1'b0, ~tbl[i].rs, ~tbl[i].single, ~tbl[i].data);
      pulses = 0; first_free = -1;
      for (int k = 1; k <= 12; k++) begin
        cycle();
        if (obs_en === 1'b1) begin
          if (pulses < 3) p[pulses] = {obs_rs, obs_data};
          pulses++;
        end
        if (first_free < 0 && obs_busy === 1'b0) first_free = k;
      end
      check("en_pulses", pulses, tbl[i].exp_pulses);
      check("nibble_hi", {27'd0, p[0]}, {27'd0, tbl[i].exp_p1});
      if (tbl[i].exp_pulses == 2) check("nibble_lo", {27'd0, p[1]}, {27'd0, tbl[i].exp_p2});
      check("next_ready", first_free, tbl[i].exp_next);
    end

    // reset mid-transfer, with both clients waiting during reset
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h28);
    waitc = 0;
    acc0 = 1'b0; acc1 = 1'b0;
    while (!(acc0 || acc1) && waitc < 40) begin
      cycle();
      waitc++;
    end
    check("accept_timeout", {31'd0, acc0}, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h41);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h42);
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    check("en_after_reset", {31'd0, obs_en}, 32'd0);
    cycle();
    check("en_after_reset", {31'd0, obs_en}, 32'd0);
    reset = 1'b0;

    // contention: grants alternate starting with req0, bytes intact
    nacc = 0; npulse = 0; waitc = 0; pend_grant = -1; byte_asm = 8'h00;
    while ((nacc < 4 || npulse < 8) && waitc < 80) begin
      cycle();
      waitc++;
      if (pend_grant >= 0) begin
        check("grant_order", {31'd0, obs_grant}, pend_grant);
        pend_grant = -1;
      end
      if (obs_en === 1'b1) begin
        if (npulse % 2 == 0) byte_asm[7:4] = obs_data;
        else begin
          byte_asm[3:0] = obs_data;
          check("contention_byte", {24'd0, byte_asm}, 8'h41 + 8'((npulse / 2) % 2));
        end
        npulse++;
      end
      if (acc0 || acc1) begin
        pend_grant = nacc % 2;
        nacc++;
      end
    end
    check("contention_timeout", {31'd0, (nacc >= 4 && npulse >= 8)}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (12) cycle();

    // random traffic: clients hold requests until accepted
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_valid[n] && $urandom_range(0, 2) == 0) begin
          p_valid[n] = 1'b1;
          p_rs[n] = 1'($urandom_range(0, 1));
          p_single[n] = ($urandom_range(0, 5) == 0);
          p_data[n] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
        end
        drive(n[0], p_valid[n], p_rs[n], p_single[n], p_data[n]);
      end
      reset = ($urandom_range(0, 99) == 0);
      cycle();
      if (acc0) p_valid[0] = 1'b0;
      if (acc1) p_valid[1] = 1'b0;
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
